// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default operand width.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the bit-slice datapath of serial_adder.
module full_adder (
  output logic s,
  output logic cout,
  input  logic x,
  input  logic y,
  input  logic cin
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, through a single full_adder slice.
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | WIDTH cycles, one operand bit pair per cycle
// FIN   | one-cycle done pulse, then back to IDLE
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s, fa_c, last_bit;

  full_adder u_fa (
    .s    (fa_s),
    .cout (fa_c),
    .x    (a_q[0]),
    .y    (b_q[0]),
    .cin  (carry_q)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they leave the block straight from flops.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    busy_d  = (state_d == RUN);
    done_d  = (state_d == FIN);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d  = {fa_s, res_q[WIDTH-1:1]};
          cout_d = fa_c;
        end
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high. The clock port is clk and the reset port is rst.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new addition; sampled on the rising edge of clk.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A, captured when start is accepted.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B, captured when start is accepted.
REQ-008 The block SHALL have port cin, input, 1 bit: initial carry, captured when start is accepted.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking sum and cout as updated.
REQ-011 The block SHALL have port sum, output, WIDTH bits: registered result, held between operations.
REQ-012 The block SHALL have port cout, output, 1 bit: registered final carry, held between operations.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FIN, with busy = (state == RUN) and done = (state == FIN).
REQ-014 In IDLE, start=1 SHALL load the A/B shift registers from a/b, load the carry flop from cin, clear the bit counter and enter RUN; start=0 SHALL leave the block in IDLE.
REQ-015 In RUN, each cycle SHALL add A[0], B[0] and the carry flop through the full_adder instance.
REQ-016 In each RUN cycle the sum bit SHALL be shifted into the MSB of the result shift register, A and B SHALL shift right one bit, the carry flop SHALL take the full_adder carry-out, and the counter SHALL increment.
REQ-017 RUN SHALL last exactly WIDTH cycles, processing bits LSB first.
REQ-018 On the final RUN cycle the block SHALL load sum from the complete result, load cout from the final carry-out, and enter FIN.
REQ-019 FIN SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-020 Latency: if start is accepted at edge N, done SHALL be high from edge N+WIDTH to edge N+WIDTH+1, with sum and cout already valid at edge N+WIDTH.
REQ-021 start SHALL be ignored in RUN and FIN; no queuing of requests.
REQ-022 Changes on a, b or cin after acceptance SHALL NOT affect the operation in progress.
REQ-023 Between completions, sum and cout SHALL hold their last values; they SHALL NOT show partial results.
REQ-024 The result SHALL equal {cout,sum} = a + b + cin modulo 2^(WIDTH+1), with no overflow flag.
REQ-025 Back-to-back operation: start held high SHALL be accepted again in the IDLE cycle that follows FIN, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-026 While rst=1, the block SHALL immediately force state=IDLE and clear busy, done, sum, cout, the carry flop, the counter and all shift registers to 0, independent of clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-028 The first start accepted after rst deasserts SHALL behave exactly as it would from power-up.

Structure
REQ-029 The shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, FIN=2'd2) and the WIDTH default; the counter width SHALL be derived as clog2(WIDTH+1).
REQ-030 The block SHALL instantiate exactly one sub-module, full_adder (ports s, cout, x, y, cin), as the bit-slice datapath; it SHALL NOT use any other adder logic.
REQ-031 All outputs SHALL be driven directly from flops, with no combinational paths from inputs to outputs.

Verification
REQ-032 Zero case: WIDTH=8, a=8'h00, b=8'h00, cin=0, start pulse at edge 0 -> done high at edge 8 only, sum=8'h00, cout=0, busy high for edges 1..8.
REQ-033 Full carry ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
REQ-034 No carry: a=8'h3C, b=8'h42, cin=0 -> sum=8'h7E, cout=0; the previous sum is held until the done edge.
REQ-035 Ignored start: start held high for 12 cycles with a=8'h10, b=8'h20, and a/b changed to 8'hFF mid-RUN -> exactly one done at edge 8, sum=8'h30, then the second operation is accepted at the edge after FIN.
REQ-036 Abort: rst asserted asynchronously at the 4th RUN cycle -> busy, done, sum and cout are 0 immediately with no done pulse; a following a=8'h01, b=8'h01 operation gives sum=8'h02.
REQ-037 Exhaustive check: WIDTH=4, all 512 combinations of a, b and cin checked against a + b + cin.
